// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750_ifu -- non-speculative instruction fetch unit.
//
// Holds the architectural PC, issues one instruction-memory request per PC,
// extracts the 32-bit instruction from the 64-bit response and offers
// {inst, pc, snpc} to IF/ID. A new PC is taken from the next-PC generator
// only after the current instruction has been handed over. A flush redirects
// the PC at any time. A response that is still in flight when the flush
// happens is swallowed by the drop flag.
//
// Ports:
//   I_clk, I_rst_n                 clock, asynchronous active-low reset
//   I_dnpc_valid/O_dnpc_ready      next-PC handshake, I_dnpc = next PC
//   I_flush, I_flush_pc            redirect, highest priority
//   O_imem_req_valid/I_imem_req_ready, O_imem_addr   fetch request
//   I_imem_rsp_valid, I_imem_rdata                   fetch response (64 bit)
//   O_IF_ID_valid/I_IF_ID_ready    instruction handshake toward IF/ID
//   O_inst, O_pc, O_snpc           fetched instruction, its PC, PC + 4
//   O_inst_misalign                misaligned-PC marker
//
// Configuration macro: YSYX_22040750_IFU_MISALIGN_EN
//   defined   - a misaligned PC skips memory and yields a NOP with
//               O_inst_misalign = 1
//   undefined - O_inst_misalign stays 0 and every PC is fetched normally
module ysyx_22040750_ifu (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_dnpc_valid,
    output logic        O_dnpc_ready,
    input  logic [31:0] I_dnpc,
    input  logic        I_flush,
    input  logic [31:0] I_flush_pc,
    output logic        O_imem_req_valid,
    input  logic        I_imem_req_ready,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_rsp_valid,
    input  logic [63:0] I_imem_rdata,
    output logic        O_IF_ID_valid,
    input  logic        I_IF_ID_ready,
    output logic [31:0] O_inst,
    output logic [31:0] O_pc,
    output logic [31:0] O_snpc,
    output logic        O_inst_misalign
);

    localparam logic [1:0]  ST_REQ   = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_OUT   = 2'd2;
    localparam logic [1:0]  ST_NEXT  = 2'd3;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

`ifdef YSYX_22040750_IFU_MISALIGN_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    // Only the two low PC bits decide alignment.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return MISALIGN_EN & (pc_lo != 2'b00);
    endfunction

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] snpc_r;
    logic [31:0] inst_r;
    logic        drop_r;
    logic        mis_r;
    logic        req_valid_r;
    logic        if_id_valid_r;
    logic        dnpc_ready_r;

    logic [1:0]  state_nx_s;
    logic [31:0] pc_nx_s;
    logic [31:0] inst_nx_s;
    logic        drop_nx_s;
    logic        mis_nx_s;
    logic        req_hs_s;

    // The request handshake is qualified by the registered valid. The valid
    // flop is held low through reset, so no request leaves during reset.
    assign req_hs_s = req_valid_r & I_imem_req_ready;

    // Next-state, next-PC and capture logic; flush overrides every other event.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        inst_nx_s  = inst_r;
        drop_nx_s  = drop_r;
        mis_nx_s   = mis_r;
        if (I_flush) begin
            pc_nx_s  = I_flush_pc;
            mis_nx_s = 1'b0;
            case (state_r)
                ST_REQ: begin
                    if (req_hs_s) begin
                        drop_nx_s  = 1'b1;
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (I_imem_rsp_valid) begin
                        drop_nx_s  = 1'b0;
                        state_nx_s = ST_REQ;
                    end else begin
                        drop_nx_s  = 1'b1;
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_OUT:  state_nx_s = ST_REQ;
                ST_NEXT: state_nx_s = ST_REQ;
                default: begin
                    drop_nx_s  = 1'b0;
                    state_nx_s = ST_REQ;
                end
            endcase
            // A misaligned target skips memory. drop stays armed if a
            // request is still in flight. Its stale response is then
            // swallowed later, or the drop costs one harmless re-fetch.
            if (pc_misaligned(I_flush_pc[1:0])) begin
                state_nx_s = ST_OUT;
                inst_nx_s  = INST_NOP;
                mis_nx_s   = 1'b1;
            end else begin
                mis_nx_s   = 1'b0;
            end
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (req_hs_s) begin
                        state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (!I_imem_rsp_valid) begin
                        state_nx_s = ST_WAIT;
                    end else if (drop_r) begin
                        drop_nx_s  = 1'b0;
                        state_nx_s = ST_REQ;
                    end else begin
                        inst_nx_s  = pc_r[2] ? I_imem_rdata[63:32] : I_imem_rdata[31:0];
                        state_nx_s = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (I_IF_ID_ready) begin
                        state_nx_s = ST_NEXT;
                    end else begin
                        state_nx_s = ST_OUT;
                    end
                end
                ST_NEXT: begin
                    if (!I_dnpc_valid) begin
                        state_nx_s = ST_NEXT;
                    end else if (pc_misaligned(I_dnpc[1:0])) begin
                        pc_nx_s    = I_dnpc;
                        inst_nx_s  = INST_NOP;
                        mis_nx_s   = 1'b1;
                        state_nx_s = ST_OUT;
                    end else begin
                        pc_nx_s    = I_dnpc;
                        mis_nx_s   = 1'b0;
                        state_nx_s = ST_REQ;
                    end
                end
                default: begin
                    drop_nx_s  = 1'b0;
                    state_nx_s = ST_REQ;
                end
            endcase
        end
    end

    // State, PC, instruction and registered handshake outputs.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_r       <= ST_REQ;
            pc_r          <= RST_PC;
            snpc_r        <= RST_PC + 32'd4;
            inst_r        <= 32'd0;
            drop_r        <= 1'b0;
            mis_r         <= 1'b0;
            req_valid_r   <= 1'b0;
            if_id_valid_r <= 1'b0;
            dnpc_ready_r  <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            pc_r          <= pc_nx_s;
            snpc_r        <= pc_nx_s + 32'd4;
            inst_r        <= inst_nx_s;
            drop_r        <= drop_nx_s;
            mis_r         <= mis_nx_s;
            req_valid_r   <= (state_nx_s == ST_REQ);
            if_id_valid_r <= (state_nx_s == ST_OUT);
            dnpc_ready_r  <= (state_nx_s == ST_NEXT);
        end
    end

    assign O_imem_req_valid = req_valid_r;
    assign O_imem_addr      = pc_r;
    assign O_IF_ID_valid    = if_id_valid_r;
    assign O_dnpc_ready     = dnpc_ready_r;
    assign O_inst           = inst_r;
    assign O_pc             = pc_r;
    assign O_snpc           = snpc_r;
    assign O_inst_misalign  = mis_r;

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Self-checking bench for ysyx_22040750_ifu: directed scenarios plus a
// randomized run checked against a transaction-level fetch model.
module tb_ysyx_22040750_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        I_clk;
    logic        I_rst_n;
    logic        I_dnpc_valid;
    logic        O_dnpc_ready;
    logic [31:0] I_dnpc;
    logic        I_flush;
    logic [31:0] I_flush_pc;
    logic        O_imem_req_valid;
    logic        I_imem_req_ready;
    logic [31:0] O_imem_addr;
    logic        I_imem_rsp_valid;
    logic [63:0] I_imem_rdata;
    logic        O_IF_ID_valid;
    logic        I_IF_ID_ready;
    logic [31:0] O_inst;
    logic [31:0] O_pc;
    logic [31:0] O_snpc;
    logic        O_inst_misalign;

    int tests_run    = 0;
    int tests_failed = 0;

    int          mem_ready_pct = 100;
    int          mem_lat       = 1;
    int          pend_cnt      = 0;
    logic [31:0] pend_addr     = 32'd0;
    logic [31:0] req_log[$];

    ysyx_22040750_ifu dut (
        .I_clk            (I_clk),
        .I_rst_n          (I_rst_n),
        .I_dnpc_valid     (I_dnpc_valid),
        .O_dnpc_ready     (O_dnpc_ready),
        .I_dnpc           (I_dnpc),
        .I_flush          (I_flush),
        .I_flush_pc       (I_flush_pc),
        .O_imem_req_valid (O_imem_req_valid),
        .I_imem_req_ready (I_imem_req_ready),
        .O_imem_addr      (O_imem_addr),
        .I_imem_rsp_valid (I_imem_rsp_valid),
        .I_imem_rdata     (I_imem_rdata),
        .O_IF_ID_valid    (O_IF_ID_valid),
        .I_IF_ID_ready    (I_IF_ID_ready),
        .O_inst           (O_inst),
        .O_pc             (O_pc),
        .O_snpc           (O_snpc),
        .O_inst_misalign  (O_inst_misalign)
    );

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory contents: the doubleword at 8000_0000 is fixed, all others are
    // derived from the address so that a stale response shows a wrong word.
    function automatic logic [63:0] mem_dw(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:3], 3'b000};
        if (base == 32'h8000_0000) return 64'h0000_0093_0000_0513;
        return {base ^ 32'h1357_9BDF, ~base ^ 32'h0246_8ACE};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [63:0] dw;
        dw = mem_dw(a);
        return a[2] ? dw[63:32] : dw[31:0];
    endfunction

    // Memory responder: one request in flight, response mem_lat cycles later.
    initial begin
        I_imem_req_ready = 1'b0;
        I_imem_rsp_valid = 1'b0;
        I_imem_rdata     = 64'd0;
        forever begin
            @(negedge I_clk);
            I_imem_rsp_valid = 1'b0;
            if (!I_rst_n) begin
                pend_cnt         = 0;
                I_imem_req_ready = 1'b0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        I_imem_rsp_valid = 1'b1;
                        I_imem_rdata     = mem_dw(pend_addr);
                    end
                end
                I_imem_req_ready = ($urandom_range(0, 99) < mem_ready_pct);
                if (O_imem_req_valid && I_imem_req_ready) begin
                    pend_addr = O_imem_addr;
                    pend_cnt  = mem_lat;
                    req_log.push_back(O_imem_addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge I_clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n = 0;
        I_IF_ID_ready = 1'b0;
        while (O_IF_ID_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ok = (O_IF_ID_valid === 1'b1);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wait_valid: O_IF_ID_valid=%b after %0d cycles, required 1", O_IF_ID_valid, n);
        end
    endtask

    task automatic drain_to_next();
        int n;
        n = 0;
        I_dnpc_valid = 1'b0;
        I_flush      = 1'b0;
        while (O_dnpc_ready !== 1'b1 && n < 100) begin
            I_IF_ID_ready = O_IF_ID_valid;
            tick();
            n++;
        end
        I_IF_ID_ready = 1'b0;
        tests_run++;
        if (O_dnpc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_to_next: O_dnpc_ready=%b after %0d cycles, required 1", O_dnpc_ready, n);
        end
    endtask

    task automatic test_reset();
        I_rst_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready, O_inst_misalign, O_inst, O_pc} !==
            {4'b0000, 32'd0, RST_PC}) begin
            tests_failed++;
            $display("FAIL reset_state: req=%b vld=%b rdy=%b mis=%b inst=%h pc=%h, required 0 0 0 0 00000000 %h",
                     O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready, O_inst_misalign, O_inst, O_pc, RST_PC);
        end
        I_rst_n = 1'b1;          // released inside cycle 0
        tests_run++;
        if (O_imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cycle0_req: got %b, required 0", O_imem_req_valid);
        end
        tick();                  // cycle 1
        tests_run++;
        if ({O_imem_req_valid, O_imem_addr} !== {1'b1, RST_PC}) begin
            tests_failed++;
            $display("FAIL reset_cycle1_req: req=%b addr=%h, required 1 %h", O_imem_req_valid, O_imem_addr, RST_PC);
        end
        tick();                  // cycle 2
        tests_run++;
        if (O_IF_ID_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cycle2_valid: got %b, required 0", O_IF_ID_valid);
        end
        tick();                  // cycle 3
        tests_run++;
        if ({O_IF_ID_valid, O_inst, O_pc, O_snpc} !== {1'b1, 32'h0000_0513, RST_PC, 32'h8000_0004}) begin
            tests_failed++;
            $display("FAIL first_fetch: vld=%b inst=%h pc=%h snpc=%h, required 1 00000513 80000000 80000004",
                     O_IF_ID_valid, O_inst, O_pc, O_snpc);
        end
    endtask

    task automatic test_stall();
        logic [95:0] held;
        held = {O_inst, O_pc, O_snpc};
        I_IF_ID_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({O_IF_ID_valid, O_dnpc_ready, O_inst, O_pc, O_snpc} !== {2'b10, held}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: vld=%b rdy=%b out=%h, required 1 0 %h",
                         i, O_IF_ID_valid, O_dnpc_ready, {O_inst, O_pc, O_snpc}, held);
            end
        end
        I_IF_ID_ready = 1'b1;
        tick();
        I_IF_ID_ready = 1'b0;
        tests_run++;
        if ({O_IF_ID_valid, O_dnpc_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL after_handshake: vld=%b dnpc_ready=%b, required 0 1", O_IF_ID_valid, O_dnpc_ready);
        end
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0004;
        tick();
        I_dnpc_valid = 1'b0;
        tests_run++;
        if ({O_imem_req_valid, O_dnpc_ready, O_imem_addr} !== {2'b10, 32'h8000_0004}) begin
            tests_failed++;
            $display("FAIL dnpc_to_req: req=%b rdy=%b addr=%h, required 1 0 80000004",
                     O_imem_req_valid, O_dnpc_ready, O_imem_addr);
        end
        tick();
        tick();
        tests_run++;
        if ({O_IF_ID_valid, O_inst, O_pc, O_snpc} !== {1'b1, 32'h0000_0093, 32'h8000_0004, 32'h8000_0008}) begin
            tests_failed++;
            $display("FAIL upper_word: vld=%b inst=%h pc=%h snpc=%h, required 1 00000093 80000004 80000008",
                     O_IF_ID_valid, O_inst, O_pc, O_snpc);
        end
    endtask

    task automatic test_loop_rate();
        int last;
        int seen;
        logic [31:0] next_pc;
        last    = -1;
        seen    = 0;
        next_pc = 32'h8000_0008;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            I_IF_ID_ready = 1'b0;
            I_dnpc_valid  = 1'b0;
            if (O_IF_ID_valid === 1'b1) begin
                if (last >= 0) begin
                    tests_run++;
                    if (c - last != 4) begin
                        tests_failed++;
                        $display("FAIL loop_period: %0d cycles per instruction, required 4", c - last);
                    end
                end
                last = c;
                seen++;
                I_IF_ID_ready = 1'b1;
            end
            if (O_dnpc_ready === 1'b1) begin
                I_dnpc_valid = 1'b1;
                I_dnpc       = next_pc;
                next_pc      = next_pc + 32'd4;
            end
            tick();
        end
        I_IF_ID_ready = 1'b0;
        I_dnpc_valid  = 1'b0;
        tests_run++;
        if (seen < 4) begin
            tests_failed++;
            $display("FAIL loop_progress: %0d instructions, required 4", seen);
        end
    endtask

    task automatic test_flush_wait();
        int base;
        int stale;
        bit got;
        drain_to_next();
        mem_lat      = 3;
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0100;
        tick();                  // REQ, accepted by memory
        I_dnpc_valid = 1'b0;
        base = req_log.size();
        tick();                  // WAIT
        I_flush    = 1'b1;
        I_flush_pc = 32'h8000_1000;
        tick();
        I_flush = 1'b0;
        mem_lat = 1;
        tests_run++;
        if ({O_imem_req_valid, O_IF_ID_valid, O_imem_addr} !== {2'b00, 32'h8000_1000}) begin
            tests_failed++;
            $display("FAIL flush_wait_hold: req=%b vld=%b addr=%h, required 0 0 80001000",
                     O_imem_req_valid, O_IF_ID_valid, O_imem_addr);
        end
        stale = 0;
        got   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (O_IF_ID_valid === 1'b1) begin
                if (O_pc !== 32'h8000_1000 || O_inst !== mem_word(32'h8000_1000)) stale++;
                got = 1'b1;
            end
            I_IF_ID_ready = O_IF_ID_valid;
            tick();
        end
        I_IF_ID_ready = 1'b0;
        tests_run++;
        if ({got, stale} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL flush_wait_output: delivered=%b wrong_outputs=%0d, required 1 0", got, stale);
        end
        tests_run++;
        if (req_log.size() <= base || req_log[base] !== 32'h8000_1000) begin
            tests_failed++;
            $display("FAIL flush_wait_refetch: %0d requests logged after flush, required first addr 80001000",
                     req_log.size() - base);
        end
    endtask

    task automatic test_flush_next();
        bit ok;
        drain_to_next();
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0040;
        I_flush      = 1'b1;
        I_flush_pc   = 32'h8000_2000;
        tick();
        I_dnpc_valid = 1'b0;
        I_flush      = 1'b0;
        tests_run++;
        if ({O_imem_req_valid, O_imem_addr} !== {1'b1, 32'h8000_2000}) begin
            tests_failed++;
            $display("FAIL flush_next_req: req=%b addr=%h, required 1 80002000", O_imem_req_valid, O_imem_addr);
        end
        wait_valid(ok);
        if (ok) begin
            tests_run++;
            if ({O_pc, O_inst} !== {32'h8000_2000, mem_word(32'h8000_2000)}) begin
                tests_failed++;
                $display("FAIL flush_next_out: pc=%h inst=%h, required 80002000 %h", O_pc, O_inst, mem_word(32'h8000_2000));
            end
        end
    endtask

    task automatic test_flush_out();
        bit ok;
        I_IF_ID_ready = 1'b1;
        I_flush       = 1'b1;
        I_flush_pc    = 32'h8000_3008;
        tick();
        I_IF_ID_ready = 1'b0;
        I_flush       = 1'b0;
        tests_run++;
        if ({O_IF_ID_valid, O_dnpc_ready, O_imem_req_valid, O_imem_addr} !== {3'b001, 32'h8000_3008}) begin
            tests_failed++;
            $display("FAIL flush_out_kill: vld=%b rdy=%b req=%b addr=%h, required 0 0 1 80003008",
                     O_IF_ID_valid, O_dnpc_ready, O_imem_req_valid, O_imem_addr);
        end
        wait_valid(ok);
        if (ok) begin
            tests_run++;
            if ({O_pc, O_inst} !== {32'h8000_3008, mem_word(32'h8000_3008)}) begin
                tests_failed++;
                $display("FAIL flush_out_refetch: pc=%h inst=%h, required 80003008 %h", O_pc, O_inst, mem_word(32'h8000_3008));
            end
        end
    endtask

    task automatic test_misalign();
        int base;
        bit ok;
        drain_to_next();
        base = req_log.size();
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0042;
        tick();
        I_dnpc_valid = 1'b0;
`ifdef YSYX_22040750_IFU_MISALIGN_EN
        tests_run++;
        if ({O_imem_req_valid, O_IF_ID_valid, O_inst_misalign, O_inst, O_pc, O_snpc} !==
            {3'b011, 32'h0000_0013, 32'h8000_0042, 32'h8000_0046}) begin
            tests_failed++;
            $display("FAIL misalign_out: req=%b vld=%b mis=%b inst=%h pc=%h snpc=%h, required 0 1 1 00000013 80000042 80000046",
                     O_imem_req_valid, O_IF_ID_valid, O_inst_misalign, O_inst, O_pc, O_snpc);
        end
        repeat (3) tick();
        tests_run++;
        if (req_log.size() != base) begin
            tests_failed++;
            $display("FAIL misalign_no_req: %0d requests issued, required 0", req_log.size() - base);
        end
        I_IF_ID_ready = 1'b1;
        tick();
        I_IF_ID_ready = 1'b0;
        I_dnpc_valid  = 1'b1;
        I_dnpc        = 32'h8000_0048;
        tick();
        I_dnpc_valid  = 1'b0;
        tests_run++;
        if ({O_inst_misalign, O_imem_req_valid, O_imem_addr} !== {2'b01, 32'h8000_0048}) begin
            tests_failed++;
            $display("FAIL misalign_clear: mis=%b req=%b addr=%h, required 0 1 80000048",
                     O_inst_misalign, O_imem_req_valid, O_imem_addr);
        end
`else
        tests_run++;
        if ({O_imem_req_valid, O_inst_misalign, O_imem_addr} !== {2'b10, 32'h8000_0042}) begin
            tests_failed++;
            $display("FAIL misalign_fetch: req=%b mis=%b addr=%h, required 1 0 80000042",
                     O_imem_req_valid, O_inst_misalign, O_imem_addr);
        end
        wait_valid(ok);
        if (ok) begin
            tests_run++;
            if ({O_inst, O_pc, O_inst_misalign} !== {mem_word(32'h8000_0042), 32'h8000_0042, 1'b0}) begin
                tests_failed++;
                $display("FAIL misalign_plain_out: inst=%h pc=%h mis=%b, required %h 80000042 0",
                         O_inst, O_pc, O_inst_misalign, mem_word(32'h8000_0042));
            end
        end
        tests_run++;
        if (req_log.size() != base + 1) begin
            tests_failed++;
            $display("FAIL misalign_req_count: %0d requests, required 1", req_log.size() - base);
        end
`endif
    endtask

    task automatic test_wrap();
        bit ok;
        drain_to_next();
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'hFFFF_FFFC;
        tick();
        I_dnpc_valid = 1'b0;
        wait_valid(ok);
        if (ok) begin
            tests_run++;
            if ({O_pc, O_snpc, O_inst} !== {32'hFFFF_FFFC, 32'd0, mem_word(32'hFFFF_FFFC)}) begin
                tests_failed++;
                $display("FAIL snpc_wrap: pc=%h snpc=%h inst=%h, required fffffffc 00000000 %h",
                         O_pc, O_snpc, O_inst, mem_word(32'hFFFF_FFFC));
            end
        end
    endtask

    // Model: the expected PC follows accepted dnpc values and flush targets.
    // Each PC is delivered once, with the memory word at that PC, and a new
    // PC is accepted only after that delivery.
    task automatic test_random();
        logic [31:0] exp_pc;
        bit          delivered;
        int          deliveries;
        deliveries = 0;
        drain_to_next();
        exp_pc       = 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
        I_dnpc_valid = 1'b1;
        I_dnpc       = exp_pc;
        delivered    = 1'b0;
        tick();
        I_dnpc_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                mem_ready_pct = $urandom_range(30, 100);
                mem_lat       = $urandom_range(1, 4);
            end
            if (O_imem_req_valid === 1'b1) begin
                tests_run++;
                if (O_imem_addr !== exp_pc) begin
                    tests_failed++;
                    $display("FAIL rand_req_addr: cycle %0d addr=%h, required %h", c, O_imem_addr, exp_pc);
                end
            end
            if (O_IF_ID_valid === 1'b1) begin
                tests_run++;
                if ({O_pc, O_inst, O_snpc, delivered, O_dnpc_ready} !==
                    {exp_pc, mem_word(exp_pc), exp_pc + 32'd4, 2'b00}) begin
                    tests_failed++;
                    $display("FAIL rand_output: cycle %0d pc=%h inst=%h snpc=%h dup=%b rdy=%b, required %h %h %h 0 0",
                             c, O_pc, O_inst, O_snpc, delivered, O_dnpc_ready,
                             exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
            end
            if (O_dnpc_ready === 1'b1) begin
                tests_run++;
                if (delivered !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rand_speculative: cycle %0d dnpc_ready=1 before delivery of %h", c, exp_pc);
                end
            end
            I_IF_ID_ready = ($urandom_range(0, 99) < 60);
            I_dnpc_valid  = ($urandom_range(0, 99) < 60);
            I_dnpc        = 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
            I_flush       = ($urandom_range(0, 99) < 4);
            I_flush_pc    = 32'h8000_0000 + ($urandom_range(0, 4095) << 2);
            if (I_flush) begin
                exp_pc    = I_flush_pc;
                delivered = 1'b0;
            end else if (O_IF_ID_valid === 1'b1 && I_IF_ID_ready) begin
                delivered = 1'b1;
                deliveries++;
            end else if (O_dnpc_ready === 1'b1 && I_dnpc_valid) begin
                exp_pc    = I_dnpc;
                delivered = 1'b0;
            end
            tick();
        end
        I_IF_ID_ready = 1'b0;
        I_dnpc_valid  = 1'b0;
        I_flush       = 1'b0;
        mem_ready_pct = 100;
        mem_lat       = 1;
        tests_run++;
        if (deliveries < 100) begin
            tests_failed++;
            $display("FAIL rand_progress: %0d instructions delivered, required at least 100", deliveries);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        drain_to_next();
        mem_lat      = 3;
        I_dnpc_valid = 1'b1;
        I_dnpc       = 32'h8000_0500;
        tick();
        I_dnpc_valid = 1'b0;
        tick();                  // WAIT with a response in flight
        #2;
        I_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready, O_pc, O_inst} !== {3'b000, RST_PC, 32'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: req=%b vld=%b rdy=%b pc=%h inst=%h, required 0 0 0 %h 00000000",
                     O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready, O_pc, O_inst, RST_PC);
        end
        tick();
        tick();
        mem_lat = 1;
        I_rst_n = 1'b1;
        tick();
        tests_run++;
        if ({O_imem_req_valid, O_imem_addr} !== {1'b1, RST_PC}) begin
            tests_failed++;
            $display("FAIL async_reset_restart: req=%b addr=%h, required 1 %h", O_imem_req_valid, O_imem_addr, RST_PC);
        end
        wait_valid(ok);
        if (ok) begin
            tests_run++;
            if ({O_pc, O_inst} !== {RST_PC, 32'h0000_0513}) begin
                tests_failed++;
                $display("FAIL async_reset_fetch: pc=%h inst=%h, required 80000000 00000513", O_pc, O_inst);
            end
        end
    endtask

    initial begin
        I_rst_n       = 1'b0;
        I_dnpc_valid  = 1'b0;
        I_dnpc        = 32'd0;
        I_flush       = 1'b0;
        I_flush_pc    = 32'd0;
        I_IF_ID_ready = 1'b0;
        test_reset();
        test_stall();
        test_loop_rate();
        test_flush_wait();
        test_flush_next();
        test_flush_out();
        test_misalign();
        test_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
